// File: rtl/sdram_wb_arbiter.sv
// rtl/sdram_wb_arbiter.sv - round-robin Wishbone arbiter in front of the sdrc_top slave port
// Grants are held for a whole wb_cyc; a stall watchdog pulses timeout_o.
module sdram_wb_arbiter #(
    parameter int NUM_M   = 2,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      sys_clk,
    input  logic                      RESETN,
    input  logic                      sdr_init_done,
    input  logic [NUM_M-1:0]          m_cyc_i,
    input  logic [NUM_M-1:0]          m_stb_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*AW-1:0]       m_addr_i,
    input  logic [NUM_M*DW-1:0]       m_dat_i,
    input  logic [NUM_M*(DW/8)-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]        m_cti_i,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic [DW-1:0]             m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [AW-1:0]             s_addr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic [2:0]                s_cti_o,
    input  logic                      s_ack_i,
    input  logic [DW-1:0]             s_dat_i,
    output logic [NUM_M-1:0]          grant_o,
    output logic                      timeout_o
);

    localparam int SW = DW / 8;
    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    last_q, last_d;
    logic [WW-1:0]    wd_q, wd_d;

    logic [NUM_M-1:0] req;
    logic [PW-1:0]    idx;
    logic             found;
    logic             busy;
    logic             sel_cyc, sel_stb, sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_dat;
    logic [SW-1:0]    sel_sel;
    logic [2:0]       sel_cti;

    assign req  = m_cyc_i & m_stb_i;
    assign busy = (state_q == ST_BUSY);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        idx     = '0;
        found   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sdr_init_done && |req) begin
                    // search starts just past the previous owner, so master 0 wins after reset
                    for (int i = 1; i <= NUM_M; i++) begin
                        idx = PW'((int'(last_q) + i) % NUM_M);
                        if (!found && req[idx]) begin
                            found  = 1'b1;
                            gidx_d = idx;
                        end
                    end
                    grant_d         = '0;
                    grant_d[gidx_d] = 1'b1;
                    state_d         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i[gidx_q]) begin
                    state_d = ST_RELEASE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_cyc  = 1'b0;
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_dat  = '0;
        sel_sel  = '0;
        sel_cti  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (gidx_q == PW'(k)) begin
                sel_cyc  = m_cyc_i[k];
                sel_stb  = m_stb_i[k];
                sel_we   = m_we_i[k];
                sel_addr = m_addr_i[k*AW +: AW];
                sel_dat  = m_dat_i[k*DW +: DW];
                sel_sel  = m_sel_i[k*SW +: SW];
                sel_cti  = m_cti_i[k*3 +: 3];
            end
        end
    end

    always_comb begin
        s_cyc_o  = busy & sel_cyc;
        s_stb_o  = busy & sel_stb;
        s_we_o   = busy & sel_we;
        s_addr_o = busy ? sel_addr : '0;
        s_dat_o  = busy ? sel_dat  : '0;
        s_sel_o  = busy ? sel_sel  : '0;
        s_cti_o  = busy ? sel_cti  : '0;
        m_ack_o  = busy ? (grant_q & {NUM_M{s_ack_i}}) : '0;
        m_dat_o  = s_dat_i;
        grant_o  = grant_q;
        timeout_o = (wd_q == WW'(TIMEOUT));
    end

    always_comb begin
        if (!s_stb_o || s_ack_i || wd_q == WW'(TIMEOUT)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= PW'(NUM_M - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// tb/tb_sdram_wb_arbiter.sv - directed self-checking bench for sdram_wb_arbiter
module tb_sdram_wb_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn;
    logic                 init_done;
    logic [1:0]           m_cyc, m_stb, m_we;
    logic [1:0][AW-1:0]   m_addr;
    logic [1:0][DW-1:0]   m_dat;
    logic [1:0][3:0]      m_sel;
    logic [1:0][2:0]      m_cti;
    logic [1:0]           m_ack;
    logic [DW-1:0]        m_rdat;
    logic                 s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdat, s_rdat;
    logic [3:0]           s_sel;
    logic [2:0]           s_cti;
    logic [1:0]           grant;
    logic                 timeout;
    logic                 ack_en;
    logic [31:0]          mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    sdram_wb_arbiter #(.NUM_M(2), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .sys_clk       (clk),
        .RESETN        (rstn),
        .sdr_init_done (init_done),
        .m_cyc_i       (m_cyc),
        .m_stb_i       (m_stb),
        .m_we_i        (m_we),
        .m_addr_i      (m_addr),
        .m_dat_i       (m_dat),
        .m_sel_i       (m_sel),
        .m_cti_i       (m_cti),
        .m_ack_o       (m_ack),
        .m_dat_o       (m_rdat),
        .s_cyc_o       (s_cyc),
        .s_stb_o       (s_stb),
        .s_we_o        (s_we),
        .s_addr_o      (s_addr),
        .s_dat_o       (s_wdat),
        .s_sel_o       (s_sel),
        .s_cti_o       (s_cti),
        .s_ack_i       (s_ack),
        .s_dat_i       (s_rdat),
        .grant_o       (grant),
        .timeout_o     (timeout)
    );

    // zero-wait slave standing in for sdrc_top
    assign s_ack  = ack_en & s_stb;
    assign s_rdat = mem[s_addr[7:0]];
    always @(posedge clk) begin
        if (s_stb && s_ack && s_we) mem[s_addr[7:0]] <= s_wdat;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    logic cyc_seen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        clear_masters();
        rstn = 1'b0; init_done = 1'b0; ack_en = 1'b1;
        tick(); tick();
        rstn = 1'b1;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_cyc", s_cyc, 1'b0);
        check("rst_ack", m_ack, 2'b00);
        check("rst_timeout", timeout, 1'b0);

        // grants blocked until SDRAM init completes
        m_cyc[0] = 1; m_stb[0] = 1; m_sel[0] = 4'hF; m_addr[0] = 26'h10;
        cyc_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc_seen = cyc_seen | s_cyc;
        end
        check("noinit_cyc", cyc_seen, 1'b0);
        init_done = 1'b1;
        tick();
        check("init_cyc", s_cyc, 1'b1);
        check("init_grant", grant, 2'b01);
        check("init_ack", m_ack, 2'b01);
        m_cyc[0] = 0; m_stb[0] = 0;
        #1;
        check("drop_cyc", s_cyc, 1'b0);
        tick(); tick();
        clear_masters();

        // simultaneous requests: m0 first, then alternation
        reset_dut();
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        check("rr_first", grant, 2'b01);
        check("rr_first_cyc", s_cyc, 1'b1);
        tick();
        m_cyc[0] = 0; m_stb[0] = 0;
        #1;
        check("rr_drop_cyc", s_cyc, 1'b0);
        tick();
        check("rr_release_grant", grant, 2'b00);
        check("rr_release_cyc", s_cyc, 1'b0);
        tick();
        check("rr_idle_cyc", s_cyc, 1'b0);
        m_cyc[0] = 1; m_stb[0] = 1;
        tick();
        check("rr_second", grant, 2'b10);
        check("rr_second_ack", m_ack, 2'b10);
        m_cyc[1] = 0; m_stb[1] = 0;
        tick(); tick(); tick();
        check("rr_third", grant, 2'b01);
        clear_masters();

        // m1 burst is not pre-empted by m0
        reset_dut();
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_sel[1] = 4'hF;
        m_addr[1] = 26'h100; m_cti[1] = 3'b010;
        tick();
        check("burst_grant", grant, 2'b10);
        m_cyc[0] = 1; m_stb[0] = 1; m_addr[0] = 26'h80; m_sel[0] = 4'hF;
        for (int b = 0; b < 4; b++) begin
            m_addr[1] = 26'h100 + 26'(4 * b);
            m_dat[1]  = 32'h1111_0000 + 32'(b);
            m_cti[1]  = (b == 3) ? 3'b111 : 3'b010;
            #1;
            check("burst_ack", m_ack, 2'b10);
            check("burst_addr", s_addr, 26'h100 + 26'(4 * b));
            check("burst_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
            tick();
        end
        m_cyc[1] = 0; m_stb[1] = 0; m_we[1] = 0;
        #1;
        check("burst_end_cyc", s_cyc, 1'b0);
        check("burst_end_ack", m_ack, 2'b00);
        tick();
        check("burst_release", grant, 2'b00);
        tick();
        check("burst_idle_cyc", s_cyc, 1'b0);
        tick();
        check("burst_next", grant, 2'b01);

        // write through m0, read back through m1
        m_we[0] = 1; m_addr[0] = 26'h40; m_dat[0] = 32'hDEAD_BEEF;
        #1;
        check("wr_we", s_we, 1'b1);
        check("wr_dat", s_wdat, 32'hDEAD_BEEF);
        check("wr_addr", s_addr, 26'h40);
        check("wr_ack", m_ack, 2'b01);
        tick();
        m_cyc[0] = 0; m_stb[0] = 0; m_we[0] = 0;
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0; m_addr[1] = 26'h40; m_cti[1] = 3'b000;
        tick(); tick(); tick();
        check("rd_grant", grant, 2'b10);
        check("rd_ack", m_ack, 2'b10);
        check("rd_data", m_rdat, 32'hDEAD_BEEF);
        clear_masters();

        // stalled slave: pulse on the 9th stalled cycle, every 9 cycles
        reset_dut();
        ack_en = 1'b0;
        m_cyc[0] = 1; m_stb[0] = 1; m_sel[0] = 4'hF;
        tick();
        for (int k = 1; k <= 18; k++) begin
            check($sformatf("wd_c%0d", k), timeout, (k == 9 || k == 18) ? 1'b1 : 1'b0);
            tick();
        end
        check("wd_grant_kept", grant, 2'b01);

        // reset mid-burst
        ack_en = 1'b1;
        m_cti[0] = 3'b010;
        m_cyc[1] = 1; m_stb[1] = 1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_cyc", s_cyc, 1'b0);
        check("midrst_grant", grant, 2'b00);
        check("midrst_ack", m_ack, 2'b00);
        tick();
        check("midrst_next", grant, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
